// File: rtl/rf_seq_pkg.sv
// Shared definitions for the register-file sequencer: opcodes, FSM states
// and default datapath sizes.
package rf_seq_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int SELW_DEF  = 3;

  localparam logic [1:0] OP_LDI = 2'b00;
  localparam logic [1:0] OP_MOV = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SUB = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC1 = 2'd1,
    ST_EXEC2 = 2'd2
  } state_e;

endpackage

// File: rtl/rf_alu8.sv
// Combinational add/subtract. For subtraction, carry is the unsigned borrow
// (a < b); zero flags an all-zero truncated result.
module rf_alu8 #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] res,
  output logic             carry,
  output logic             zero
);

  logic [WIDTH:0] sum;

  // One extra bit captures carry-out on add and borrow on subtract.
  always_comb begin
    if (sub) begin
      sum = {1'b0, a} - {1'b0, b};
    end else begin
      sum = {1'b0, a} + {1'b0, b};
    end
    res   = sum[WIDTH-1:0];
    carry = sum[WIDTH];
    zero  = (sum[WIDTH-1:0] == '0);
  end

endmodule

// File: rtl/rf_sequencer.sv
// Command sequencer in front of an 8x8 register file that reloads the
// write-selected register on every clock edge. Whenever no write is wanted
// the sequencer reads and writes the same register so its value recirculates.
//
// Command handshake: a command transfers on the rising edge where
// cmd_valid && cmd_ready. cmd_ready depends only on state and reset, never on
// cmd_valid. A held cmd_valid while cmd_ready is low is not consumed.
module rf_sequencer
  import rf_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SELW  = SELW_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [SELW-1:0]  cmd_rd,
  input  logic [SELW-1:0]  cmd_rs,
  input  logic [WIDTH-1:0] cmd_imm,
  output logic [WIDTH-1:0] rf_din,
  output logic [SELW-1:0]  rf_read,
  output logic [SELW-1:0]  rf_write,
  input  logic [WIDTH-1:0] rf_dout,
  output logic             done,
  output logic [WIDTH-1:0] res_data,
  output logic             flag_z,
  output logic             flag_c,
  output state_e           dbg_state
);

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [SELW-1:0]  rd_q, rd_d;
  logic [SELW-1:0]  rs_q, rs_d;
  logic [WIDTH-1:0] imm_q, imm_d;
  logic [SELW-1:0]  hold_q, hold_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             z_q, z_d;
  logic             c_q, c_d;

  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;
  logic             alu_zero;

  rf_alu8 #(.WIDTH(WIDTH)) u_alu (
    .a     (a_q),
    .b     (rf_dout),
    .sub   (op_q == OP_SUB),
    .res   (alu_res),
    .carry (alu_carry),
    .zero  (alu_zero)
  );

  assign cmd_ready = (state_q == ST_IDLE) && reset;
  assign done      = done_q;
  assign res_data  = res_q;
  assign flag_z    = z_q;
  assign flag_c    = c_q;
  assign dbg_state = state_q;

  // Next-state, register-file drive and result capture; hold is the default.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rd_d     = rd_q;
    rs_d     = rs_q;
    imm_d    = imm_q;
    hold_d   = hold_q;
    a_d      = a_q;
    done_d   = 1'b0;
    res_d    = res_q;
    z_d      = z_q;
    c_d      = c_q;
    rf_read  = hold_q;
    rf_write = hold_q;
    rf_din   = rf_dout;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          op_d    = cmd_op;
          rd_d    = cmd_rd;
          rs_d    = cmd_rs;
          imm_d   = cmd_imm;
          hold_d  = cmd_rd;
          state_d = ST_EXEC1;
        end
      end

      ST_EXEC1: begin
        case (op_q)
          OP_LDI: begin
            rf_read  = rd_q;
            rf_write = rd_q;
            rf_din   = imm_q;
            res_d    = imm_q;
            z_d      = (imm_q == '0);
            c_d      = 1'b0;
            done_d   = 1'b1;
            state_d  = ST_IDLE;
          end
          OP_MOV: begin
            rf_read  = rs_q;
            rf_write = rd_q;
            rf_din   = rf_dout;
            res_d    = rf_dout;
            z_d      = (rf_dout == '0);
            c_d      = 1'b0;
            done_d   = 1'b1;
            state_d  = ST_IDLE;
          end
          default: begin
            // ADD/SUB: rd recirculates while its value is captured as operand A.
            a_d     = rf_dout;
            state_d = ST_EXEC2;
          end
        endcase
      end

      ST_EXEC2: begin
        rf_read  = rs_q;
        rf_write = rd_q;
        rf_din   = alu_res;
        res_d    = alu_res;
        z_d      = alu_zero;
        c_d      = alu_carry;
        done_d   = 1'b1;
        state_d  = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and latch registers; async reset abandons any pending write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      rd_q    <= '0;
      rs_q    <= '0;
      imm_q   <= '0;
      hold_q  <= '0;
      a_q     <= '0;
      done_q  <= 1'b0;
      res_q   <= '0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      rs_q    <= rs_d;
      imm_q   <= imm_d;
      hold_q  <= hold_d;
      a_q     <= a_d;
      done_q  <= done_d;
      res_q   <= res_d;
      z_q     <= z_d;
      c_q     <= c_d;
    end
  end

endmodule
